// File: rtl/wb_mem_stage.sv
// Write-back / memory stage: owns r2..r7 and the PC, commits execute results
// and performs RAM accesses over a req/ack handshake with a wait timeout.
module wb_mem_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] res,
    input  logic        res_from_ram,
    input  logic [2:0]  res_target,
    input  logic [15:0] ram_addr,
    input  logic        ram_op,
    input  logic [15:0] ram_write,
    input  logic [3:0]  ram_mode,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [3:0]  mem_mode,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [95:0] reg_file,
    output logic [15:0] pc,
    output logic        fault
);

    localparam int unsigned DW       = 16;
    localparam int unsigned NREG     = 6;
    localparam logic [DW-1:0] TO_LIMIT = DW'(ACK_TIMEOUT);
    localparam bit          TO_EN    = (ACK_TIMEOUT != 0);

    typedef enum logic [1:0] {S_IDLE, S_MEM, S_FAULT} state_t;

    state_t                   state;
    logic [NREG-1:0][DW-1:0]  gpr;
    logic [2:0]               dest_q;
    logic [DW-1:0]            wait_cnt;

    logic          accept_c;
    logic          ack_c;
    logic          timeout_c;
    logic          commit_en_c;
    logic [2:0]    commit_tgt_c;
    logic [DW-1:0] commit_val_c;

    assign reg_file  = gpr;
    assign accept_c  = in_valid && in_ready && (state == S_IDLE);
    assign ack_c     = (state == S_MEM) && mem_req && mem_ack;
    // An ack on the expiry edge takes priority over the timeout.
    assign timeout_c = TO_EN && (state == S_MEM) && !mem_ack
                       && ((wait_cnt + DW'(1)) == TO_LIMIT);

    // Select what gets committed this edge: a direct ALU result or load data.
    always_comb begin
        commit_en_c  = 1'b0;
        commit_tgt_c = res_target;
        commit_val_c = res;
        if (accept_c && !res_from_ram) begin
            commit_en_c = 1'b1;
        end else if (ack_c) begin
            commit_en_c  = 1'b1;
            commit_tgt_c = mem_we ? 3'd0 : dest_q;
            commit_val_c = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            gpr       <= '0;
            pc        <= RESET_PC;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_mode  <= '0;
            dest_q    <= '0;
            wait_cnt  <= '0;
            fault     <= 1'b0;
        end else begin
            if (commit_en_c) begin
                if (commit_tgt_c == 3'd1) begin
                    pc <= commit_val_c;
                end else begin
                    pc <= pc + DW'(1);
                    for (int i = 0; i < NREG; i++) begin
                        if (commit_tgt_c == 3'(i + 2)) gpr[i] <= commit_val_c;
                    end
                end
            end

            case (state)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    if (accept_c && res_from_ram) begin
                        mem_addr  <= ram_addr;
                        mem_wdata <= ram_write;
                        mem_we    <= ram_op;
                        mem_mode  <= ram_mode;
                        dest_q    <= res_target;
                        mem_req   <= 1'b1;
                        wait_cnt  <= '0;
                        in_ready  <= 1'b0;
                        state     <= S_MEM;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        in_ready <= 1'b1;
                        state    <= S_IDLE;
                    end else if (timeout_c) begin
                        fault   <= 1'b1;
                        mem_req <= 1'b0;
                        state   <= S_FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + DW'(1);
                    end
                end
                S_FAULT: begin
                    in_ready <= 1'b0;
                    mem_req  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/wb_mem_stage.md
Name: wb_mem_stage

Overview:
- Sequential stage directly downstream of the combinational execute/decode unit.
- Owns the architectural state: six general registers r2..r7 and the PC.
- Consumes the execute results (res, res_target, res_from_ram, ram_* fields) and performs the RAM access through a req/ack handshake.
- Commits results to the register file or PC, then advances the PC; feeds reg_file and pc back to the execute unit.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- ACK_TIMEOUT, 255, maximum cycles mem_req may wait for mem_ack before fault; 0 disables the timeout.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  execute outputs are valid this cycle.
- in_ready  out  1  stage accepts this cycle.
- res  in  16  result value or branch target.
- res_from_ram  in  1  instruction needs a RAM access.
- res_target  in  3  destination: 0 = none, 1 = PC, 2..7 = r2..r7.
- ram_addr  in  16  access address.
- ram_op  in  1  0 = load, 1 = store.
- ram_write  in  16  store data.
- ram_mode  in  4  access mode, forwarded unmodified.
- mem_req  out  1  RAM request.
- mem_we  out  1  RAM write enable.
- mem_addr  out  16  RAM address.
- mem_wdata  out  16  RAM write data.
- mem_mode  out  4  RAM mode.
- mem_ack  in  1  RAM completion; sampled only while mem_req = 1.
- mem_rdata  in  16  load data; valid with mem_ack.
- reg_file  out  96  {r7,r6,r5,r4,r3,r2}; r2 occupies [15:0].
- pc  out  16  current PC.
- fault  out  1  sticky memory-timeout flag.

Behaviour:
- Reset is asynchronous, active-low. While rst_n = 0:
  - reg_file = 0, pc = RESET_PC.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_mode = 0.
  - fault = 0, state = IDLE.
  - in_ready = 0 while rst_n = 0 (registered); 1 from the first clock after release.
- States:
  - IDLE: in_ready = 1.
  - MEM: in_ready = 0; mem_* outputs are registered and held stable.
  - FAULT: in_ready = 0, mem_req = 0; only reset exits.
- IDLE, accepted transfer with res_from_ram = 0:
  - Commit on the same edge. res_target 0 discards; 2..7 writes res to r[t]; pc <= pc+1 (16-bit wrap).
  - res_target = 1 sets pc <= res, with no increment.
  - Throughput: 1 instruction per cycle.
- IDLE, accepted transfer with res_from_ram = 1:
  - Latch on the accept edge: mem_addr <= ram_addr, mem_wdata <= ram_write, mem_we <= ram_op, mem_mode <= ram_mode.
  - Also latch res_target into a hidden destination register.
  - Set mem_req <= 1 and go to MEM.
- MEM, mem_ack = 1 sampled: on that edge mem_req <= 0, mem_we <= 0 and the stage returns to IDLE.
  - Load: latched target 2..7 gets mem_rdata; target 1 sets pc <= mem_rdata, with no increment; target 0 discards the data.
  - Store: no register write.
  - In every case except a load with target 1, pc <= pc+1.
  - Minimum latency of a memory instruction: accept edge, then ack edge at least 1 cycle later. in_ready returns to 1 the cycle after the ack.
- mem_ack while mem_req = 0 is ignored.
- mem_ack at the same edge the timeout expires: the ack wins.
- Timeout (ACK_TIMEOUT > 0):
  - A 16-bit wait counter clears on entering MEM and increments each MEM cycle without ack.
  - When the counter reaches ACK_TIMEOUT: fault <= 1, mem_req <= 0, state goes to FAULT.
  - No register or PC update occurs on a timeout.
- reg_file and pc are purely registered; no combinational path from inputs.
- Reset asserted during MEM aborts the access immediately; mem_req drops asynchronously. The memory side must tolerate a dropped request.

Test Plan:
- Reset with RESET_PC = 16'h0010 → pc = 16'h0010, reg_file = 0, mem_req = 0, in_ready = 1 on the first clock after release.
- ALU write: in_valid, res = 16'h1234, res_target = 3, res_from_ram = 0 → r3 = 16'h1234 and pc+1 after 1 edge; 4 back-to-back ALU ops take 4 cycles.
- Branch: res_target = 1, res = 16'h00F0 → pc = 16'h00F0 (no increment); pc = 16'hFFFF with a non-branch op → pc wraps to 0.
- Load: ram_addr = 16'h0040, ram_op = 0, res_target = 5 → mem_req = 1 with mem_we = 0 until mem_ack arrives 3 cycles later with mem_rdata = 16'hBEEF → r5 = 16'hBEEF, pc+1, in_ready is 0 for exactly the wait cycles.
- Store: ram_op = 1, ram_write = 16'hA5A5, ram_mode = 4'b0011 → mem_we = 1, mem_wdata = 16'hA5A5, mem_mode = 4'b0011 held until ack; no register changes.
- Timeout with ACK_TIMEOUT = 4 and no ack → fault = 1 after 4 MEM cycles, mem_req = 0, in_ready stuck at 0. A separate run asserts rst_n low mid-MEM → mem_req falls without a clock and the state returns to reset values.
